class_result_ctrl: RTL and testbench

//  Consumer end of the matrix-multiply result interface. When product_rdy

---
 rtl/class_result_ctrl_pkg.sv | 16 +
 rtl/hex_to_7seg.sv | 30 +++
 rtl/class_result_ctrl.sv | 135 +++++++++++++
 tb/tb_class_result_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/class_result_ctrl_pkg.sv
// rtl/class_result_ctrl_pkg.sv - network sizing constants and FSM state type for the class result controller
package class_result_ctrl_pkg;

  localparam int NET_NUM_CLASSES        = 2;
  localparam int NET_FFN_OUT_BITWIDTH   = 31;
  localparam int NET_CLASS_IDX_BITWIDTH = (NET_NUM_CLASSES > 1) ? $clog2(NET_NUM_CLASSES) : 1;

  localparam logic [6:0] HEX_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_HOLD
  } crc_state_e;

endpackage

// File: rtl/hex_to_7seg.sv
// rtl/hex_to_7seg.sv - 4-bit nibble to active-low seven-segment pattern, bit order gfedcba
module hex_to_7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/class_result_ctrl.sv
// rtl/class_result_ctrl.sv - snapshots class sums, scans one class per cycle for winner and margin, presents result on valid/ready
module class_result_ctrl
  import class_result_ctrl_pkg::*;
#(
  parameter int NUM_CLASSES = NET_NUM_CLASSES,
  parameter int SUM_WIDTH   = NET_FFN_OUT_BITWIDTH + 1,
  parameter int IDX_WIDTH   = NET_CLASS_IDX_BITWIDTH
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             product_rdy,
  input  logic [NUM_CLASSES*SUM_WIDTH-1:0] sum_vector,
  input  logic                             result_ready,
  output logic                             result_valid,
  output logic [IDX_WIDTH-1:0]             class_idx,
  output logic [SUM_WIDTH-1:0]             max_sum,
  output logic [SUM_WIDTH-1:0]             margin,
  output logic                             overrun,
  output logic [6:0]                       hex_class
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam logic [SUM_WIDTH-1:0] MOST_NEG = {1'b1, {(SUM_WIDTH-1){1'b0}}};

  crc_state_e                       state;
  logic [NUM_CLASSES*SUM_WIDTH-1:0] snapshot;
  logic [IDX_WIDTH-1:0]             scan_idx;
  logic [IDX_WIDTH-1:0]             best_idx;
  logic signed [SUM_WIDTH-1:0]      best_val;
  logic signed [SUM_WIDTH-1:0]      second_val;

  logic signed [SUM_WIDTH-1:0]      cur_val;
  logic [IDX_WIDTH-1:0]             nxt_best_idx;
  logic signed [SUM_WIDTH-1:0]      nxt_best_val;
  logic signed [SUM_WIDTH-1:0]      nxt_second_val;
  logic [SUM_WIDTH:0]               diff;
  logic [3:0]                       hex_nibble;
  logic [6:0]                       hex_seg;
  logic                             accept;

  // A pulse is only taken when idle or in the very cycle the held result leaves.
  assign accept = product_rdy &&
                  ((state == ST_IDLE) || ((state == ST_HOLD) && result_ready));

  always_comb begin
    cur_val        = snapshot[int'(scan_idx)*SUM_WIDTH +: SUM_WIDTH];
    nxt_best_idx   = best_idx;
    nxt_best_val   = best_val;
    nxt_second_val = second_val;
    if (state == ST_SCAN) begin
      if (cur_val > best_val) begin
        nxt_second_val = best_val;
        nxt_best_val   = cur_val;
        nxt_best_idx   = scan_idx;
      end else if (cur_val > second_val) begin
        nxt_second_val = cur_val;
      end
    end
  end

  // Sign-extended subtraction cannot overflow; the difference is non-negative.
  assign diff       = {nxt_best_val[SUM_WIDTH-1], nxt_best_val} -
                      {nxt_second_val[SUM_WIDTH-1], nxt_second_val};
  assign hex_nibble = (state == ST_SCAN) ? 4'(nxt_best_idx) : 4'h0;

  hex_to_7seg u_hex (
    .nibble (hex_nibble),
    .seg    (hex_seg)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      snapshot     <= '0;
      scan_idx     <= '0;
      best_idx     <= '0;
      best_val     <= '0;
      second_val   <= '0;
      result_valid <= 1'b0;
      class_idx    <= '0;
      max_sum      <= '0;
      margin       <= '0;
      overrun      <= 1'b0;
      hex_class    <= HEX_BLANK;
    end else begin
      if (product_rdy && !accept) begin
        overrun <= 1'b1;
      end

      case (state)
        ST_IDLE, ST_HOLD: begin
          if ((state == ST_HOLD) && result_ready) begin
            result_valid <= 1'b0;
            state        <= ST_IDLE;
          end
          if (accept) begin
            snapshot   <= sum_vector;
            best_idx   <= '0;
            best_val   <= sum_vector[SUM_WIDTH-1:0];
            second_val <= MOST_NEG;
            scan_idx   <= IDX_WIDTH'(1);
            if (NUM_CLASSES == 1) begin
              state        <= ST_HOLD;
              result_valid <= 1'b1;
              class_idx    <= '0;
              max_sum      <= sum_vector[SUM_WIDTH-1:0];
              margin       <= '1;
              hex_class    <= hex_seg;
            end else begin
              state <= ST_SCAN;
            end
          end
        end

        ST_SCAN: begin
          best_idx   <= nxt_best_idx;
          best_val   <= nxt_best_val;
          second_val <= nxt_second_val;
          scan_idx   <= scan_idx + IDX_WIDTH'(1);
          if (scan_idx == LAST_IDX) begin
            state        <= ST_HOLD;
            result_valid <= 1'b1;
            class_idx    <= nxt_best_idx;
            max_sum      <= nxt_best_val;
            margin       <= diff[SUM_WIDTH-1:0];
            hex_class    <= hex_seg;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_class_result_ctrl.sv
// tb/tb_class_result_ctrl.sv - directed-vector bench for class_result_ctrl with 2-class and 4-class instances
module tb_class_result_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         p2 = 1'b0;
  logic [63:0]  sv2 = '0;
  logic         r2 = 1'b0;
  logic         v2;
  logic [0:0]   idx2;
  logic [31:0]  max2;
  logic [31:0]  mar2;
  logic         ovr2;
  logic [6:0]   hex2;

  logic         p4 = 1'b0;
  logic [127:0] sv4 = '0;
  logic         r4 = 1'b1;
  logic         v4;
  logic [1:0]   idx4;
  logic [31:0]  max4;
  logic [31:0]  mar4;
  logic         ovr4;
  logic [6:0]   hex4;

  int n_checks = 0;
  int n_pass   = 0;
  int xfer_cnt = 0;

  always #5 clk = ~clk;

  class_result_ctrl #(.NUM_CLASSES(2), .SUM_WIDTH(32), .IDX_WIDTH(1)) u_dut2 (
    .clock        (clk),
    .reset        (rst),
    .product_rdy  (p2),
    .sum_vector   (sv2),
    .result_ready (r2),
    .result_valid (v2),
    .class_idx    (idx2),
    .max_sum      (max2),
    .margin       (mar2),
    .overrun      (ovr2),
    .hex_class    (hex2)
  );

  class_result_ctrl #(.NUM_CLASSES(4), .SUM_WIDTH(32), .IDX_WIDTH(2)) u_dut4 (
    .clock        (clk),
    .reset        (rst),
    .product_rdy  (p4),
    .sum_vector   (sv4),
    .result_ready (r4),
    .result_valid (v4),
    .class_idx    (idx4),
    .max_sum      (max4),
    .margin       (mar4),
    .overrun      (ovr4),
    .hex_class    (hex4)
  );

  always @(posedge clk) begin
    if (v2 && r2) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic pulse2(input logic [31:0] s0, input logic [31:0] s1);
    @(negedge clk);
    sv2 = {s1, s0};
    p2  = 1'b1;
    @(negedge clk);
    p2  = 1'b0;
  endtask

  task automatic wait_valid2(input int exp_lat);
    int lat = 1;
    while (!v2 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency2", 64'(lat), 64'(exp_lat));
  endtask

  task automatic run4(input logic [31:0] s0, input logic [31:0] s1,
                      input logic [31:0] s2, input logic [31:0] s3);
    int lat = 1;
    @(negedge clk);
    sv4 = {s3, s2, s1, s0};
    p4  = 1'b1;
    @(negedge clk);
    p4  = 1'b0;
    while (!v4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency4", 64'(lat), 64'd4);
  endtask

  initial begin
    int xfer_before;
    repeat (2) @(negedge clk);
    check("rst_valid", v2, 0);
    check("rst_idx", idx2, 0);
    check("rst_max", max2, 0);
    check("rst_margin", mar2, 0);
    check("rst_overrun", ovr2, 0);
    check("rst_hex", hex2, 7'h7F);
    rst = 1'b0;

    // basic winner at the last class
    r2 = 1'b1;
    pulse2(32'd100, 32'd250);
    check("t1_not_early", v2, 0);
    wait_valid2(2);
    check("t1_idx", idx2, 1);
    check("t1_max", max2, 32'd250);
    check("t1_margin", mar2, 32'd150);
    check("t1_hex", hex2, 7'h79);
    @(negedge clk);
    check("t1_xfer", v2, 0);
    check("t1_keep_idx", idx2, 1);

    // negative sums, then a tie
    pulse2(32'hFFFF_FFFB, 32'hFFFF_FFEC);
    wait_valid2(2);
    check("t2_idx", idx2, 0);
    check("t2_max", max2, 32'hFFFF_FFFB);
    check("t2_margin", mar2, 32'd15);
    check("t2_hex", hex2, 7'h40);
    pulse2(32'd7, 32'd7);
    wait_valid2(2);
    check("t2_tie_idx", idx2, 0);
    check("t2_tie_margin", mar2, 0);

    // back-pressure, dropped pulse during hold
    @(negedge clk);
    r2 = 1'b0;
    pulse2(32'd10, 32'd4);
    wait_valid2(2);
    check("t3_max", max2, 32'd10);
    check("t3_margin", mar2, 32'd6);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) begin
        sv2 = {32'd99, 32'd1};
        p2  = 1'b1;
      end else begin
        p2 = 1'b0;
      end
      check("t3_hold_valid", v2, 1);
      check("t3_hold_max", max2, 32'd10);
      check("t3_hold_idx", idx2, 0);
    end
    check("t3_overrun", ovr2, 1);
    check("t3_margin_kept", mar2, 32'd6);
    xfer_before = xfer_cnt;
    r2 = 1'b1;
    repeat (4) @(negedge clk);
    check("t3_one_xfer", 64'(xfer_cnt - xfer_before), 1);
    check("t3_valid_low", v2, 0);
    check("t3_overrun_sticky", ovr2, 1);

    // reset mid-scan
    pulse2(32'd1, 32'd50);
    #2 rst = 1'b1;
    #1;
    check("t5_valid", v2, 0);
    check("t5_idx", idx2, 0);
    check("t5_hex", hex2, 7'h7F);
    check("t5_overrun", ovr2, 0);
    check("t5_max", max2, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_no_stale", v2, 0);
    pulse2(32'd3, 32'd8);
    wait_valid2(2);
    check("t5_idx_after", idx2, 1);
    check("t5_max_after", max2, 32'd8);
    check("t5_margin_after", mar2, 32'd5);

    // pulse accepted in the transfer cycle
    @(negedge clk);
    r2 = 1'b0;
    pulse2(32'd20, 32'd30);
    wait_valid2(2);
    check("t4_first_idx", idx2, 1);
    sv2 = {32'd1, 32'd3};
    p2  = 1'b1;
    r2  = 1'b1;
    @(negedge clk);
    p2  = 1'b0;
    check("t4_scan_valid", v2, 0);
    check("t4_keep_max", max2, 32'd30);
    @(negedge clk);
    check("t4_valid", v2, 1);
    check("t4_idx", idx2, 0);
    check("t4_max", max2, 32'd3);
    check("t4_margin", mar2, 32'd2);
    check("t4_overrun", ovr2, 0);

    // four-class instance
    run4(32'd3, 32'd9, 32'd9, 32'hFFFF_FFFF);
    check("t6_idx", idx4, 1);
    check("t6_max", max4, 32'd9);
    check("t6_margin", mar4, 0);
    check("t6_hex", hex4, 7'h79);
    run4(32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FF9C, 32'd5);
    check("t6b_idx", idx4, 3);
    check("t6b_max", max4, 32'd5);
    check("t6b_margin", mar4, 32'd8);
    check("t6b_hex", hex4, 7'h30);
    check("t6_overrun", ovr4, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
